// File: rtl/multi_dispense_timer_pkg.sv
// Shared types and default widths for the multi-channel dispense timer.
package multi_dispense_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam int CNT_W_DEF  = 31;
  localparam int REP_W_DEF  = 8;
  localparam int NUM_CH_DEF = 4;

endpackage

// File: rtl/multi_dispense_timer_if.sv
// Control/valve bus between the HPS register block (master) and the timer (slave).
interface multi_dispense_timer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 31,
  parameter int REP_W  = 8
);
  logic [NUM_CH*CNT_W-1:0] on_time;
  logic [NUM_CH*CNT_W-1:0] off_time;
  logic [NUM_CH*REP_W-1:0] repeat_cnt;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       abort;
  logic [NUM_CH-1:0]       dispense_sig;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done_pulse;

  modport master (
    output on_time, off_time, repeat_cnt, start, abort,
    input  dispense_sig, busy, done_pulse
  );

  modport slave (
    input  on_time, off_time, repeat_cnt, start, abort,
    output dispense_sig, busy, done_pulse
  );
endinterface

// File: rtl/multi_dispense_timer_dispense_channel.sv
// One dispense channel: start edge detect, shadowed timing, ON/OFF pulse-train FSM.
module dispense_channel
  import multi_dispense_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] on_time,
  input  logic [CNT_W-1:0] off_time,
  input  logic [REP_W-1:0] repeat_cnt,
  output logic             dispense_sig,
  output logic             busy,
  output logic             done_pulse
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_t           state_reg;
  logic             start_q_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] on_reg;
  logic [CNT_W-1:0] off_reg;
  logic [REP_W-1:0] rem_reg;
  logic             dispense_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             trigger;

  assign trigger      = start & ~start_q_reg;
  assign dispense_sig = dispense_reg;
  assign busy         = busy_reg;
  assign done_pulse   = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      start_q_reg  <= 1'b1;  // a start held through reset must not look like an edge
      cnt_reg      <= '0;
      on_reg       <= '0;
      off_reg      <= '0;
      rem_reg      <= '0;
      dispense_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      start_q_reg <= start;
      done_reg    <= 1'b0;
      if (abort) begin
        state_reg    <= IDLE;
        cnt_reg      <= '0;
        rem_reg      <= '0;
        dispense_reg <= 1'b0;
        busy_reg     <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (trigger) begin
              on_reg  <= on_time;
              off_reg <= off_time;
              rem_reg <= (repeat_cnt == '0) ? REP_ONE : repeat_cnt;
              cnt_reg <= '0;
              if (on_time == '0) begin
                done_reg <= 1'b1;
              end else begin
                state_reg    <= ON;
                dispense_reg <= 1'b1;
                busy_reg     <= 1'b1;
              end
            end
          end
          ON: begin
            if (cnt_reg == on_reg - CNT_ONE) begin
              cnt_reg <= '0;
              rem_reg <= rem_reg - REP_ONE;
              // rem_reg > 1 means pulses remain after this one
              if (rem_reg > REP_ONE) begin
                if (off_reg != '0) begin
                  state_reg    <= OFF;
                  dispense_reg <= 1'b0;
                end
              end else begin
                state_reg    <= IDLE;
                dispense_reg <= 1'b0;
                busy_reg     <= 1'b0;
                done_reg     <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          OFF: begin
            if (cnt_reg == off_reg - CNT_ONE) begin
              cnt_reg      <= '0;
              state_reg    <= ON;
              dispense_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_reg    <= IDLE;
            dispense_reg <= 1'b0;
            busy_reg     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_dispense_timer.sv
// Multi-channel dispense timer: NUM_CH independent channels on flattened register buses.
module multi_dispense_timer
  import multi_dispense_timer_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int REP_W  = REP_W_DEF
) (
  input  logic                   FPGA_CLK1_50,
  input  logic                   reset_n,
  multi_dispense_timer_if.slave  bus
);

  logic [NUM_CH-1:0] dispense_all;
  logic [NUM_CH-1:0] busy_all;
  logic [NUM_CH-1:0] done_all;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      dispense_channel #(
        .CNT_W (CNT_W),
        .REP_W (REP_W)
      ) u_ch (
        .clk          (FPGA_CLK1_50),
        .rst_n        (reset_n),
        .start        (bus.start[gi]),
        .abort        (bus.abort[gi]),
        .on_time      (bus.on_time[gi*CNT_W +: CNT_W]),
        .off_time     (bus.off_time[gi*CNT_W +: CNT_W]),
        .repeat_cnt   (bus.repeat_cnt[gi*REP_W +: REP_W]),
        .dispense_sig (dispense_all[gi]),
        .busy         (busy_all[gi]),
        .done_pulse   (done_all[gi])
      );
    end
  endgenerate

  assign bus.dispense_sig = dispense_all;
  assign bus.busy         = busy_all;
  assign bus.done_pulse   = done_all;

endmodule

// File: tb/tb_multi_dispense_timer.sv
// Directed bench: table of pulse-train vectors plus hand sequences for abort, reset and edge cases.
module tb_multi_dispense_timer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 31;
  localparam int REP_W  = 8;

  typedef struct {
    int               ch;
    logic [CNT_W-1:0] on_t;
    logic [CNT_W-1:0] off_t;
    logic [REP_W-1:0] rep;
    int               len;   // expected busy length in cycles
    logic [63:0]      pat;   // expected dispense_sig, bit i = i-th cycle after the trigger edge
  } vec_t;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  vec_t vecs [6];

  multi_dispense_timer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .REP_W(REP_W)) bus ();

  multi_dispense_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .FPGA_CLK1_50 (clk),
    .reset_n      (reset_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int ch, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s ch%0d: got %h expected %h", name, ch, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [CNT_W-1:0] on_t, input logic [CNT_W-1:0] off_t,
                        input logic [REP_W-1:0] rep);
    bus.on_time[ch*CNT_W +: CNT_W]    = on_t;
    bus.off_time[ch*CNT_W +: CNT_W]   = off_t;
    bus.repeat_cnt[ch*REP_W +: REP_W] = rep;
  endtask

  // Start vecs[first .. first+n-1] together (distinct channels) and compare each train.
  task automatic run_group(input int first, input int n, input bit perturb);
    logic [63:0] obs [4];
    logic [63:0] bsy [4];
    logic [63:0] dn  [4];
    int maxlen;
    maxlen = 0;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      set_ch(vecs[first+k].ch, vecs[first+k].on_t, vecs[first+k].off_t, vecs[first+k].rep);
      bus.start[vecs[first+k].ch] = 1'b1;
      if (vecs[first+k].len > maxlen) maxlen = vecs[first+k].len;
      obs[k] = '0; bsy[k] = '0; dn[k] = '0;
    end
    @(posedge clk);
    for (int i = 0; i < maxlen + 2; i++) begin
      @(negedge clk);
      if (perturb && i == 1) begin
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 31'd20, 31'd7, 8'd9);
      end
      for (int k = 0; k < n; k++) begin
        obs[k][i] = bus.dispense_sig[vecs[first+k].ch];
        bsy[k][i] = bus.busy[vecs[first+k].ch];
        dn[k][i]  = bus.done_pulse[vecs[first+k].ch];
      end
    end
    for (int k = 0; k < n; k++) begin
      chk("pattern", vecs[first+k].ch, obs[k], vecs[first+k].pat);
      chk("busy", vecs[first+k].ch, bsy[k], (64'd1 << vecs[first+k].len) - 64'd1);
      chk("done", vecs[first+k].ch, dn[k], 64'd1 << vecs[first+k].len);
      $display("[TB] vec %0d ch%0d on=%0d off=%0d rep=%0d pattern=%h", first+k, vecs[first+k].ch,
               vecs[first+k].on_t, vecs[first+k].off_t, vecs[first+k].rep, obs[k]);
    end
    bus.start = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [63:0] acc;
    logic [63:0] dacc;
    int hi;
    tests = 0;
    fails = 0;

    vecs[0] = '{ch: 0, on_t: 31'd5, off_t: 31'd0, rep: 8'd1, len: 5,  pat: 64'b11111};
    vecs[1] = '{ch: 1, on_t: 31'd3, off_t: 31'd2, rep: 8'd3, len: 13, pat: 64'b1110011100111};
    vecs[2] = '{ch: 2, on_t: 31'd4, off_t: 31'd0, rep: 8'd2, len: 8,  pat: 64'b11111111};
    vecs[3] = '{ch: 3, on_t: 31'd1, off_t: 31'd1, rep: 8'd4, len: 7,  pat: 64'b1010101};
    vecs[4] = '{ch: 3, on_t: 31'd2, off_t: 31'd3, rep: 8'd0, len: 2,  pat: 64'b11};
    vecs[5] = '{ch: 0, on_t: 31'd2, off_t: 31'd1, rep: 8'd2, len: 5,  pat: 64'b11011};

    // Reset with start held high: nothing may fire after release.
    reset_n = 1'b0;
    bus.start = '1;
    bus.abort = '0;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 31'd5, 31'd0, 8'd1);
    repeat (3) @(negedge clk);
    chk("reset_outputs", 0, {40'd0, bus.dispense_sig, bus.busy, bus.done_pulse}, 64'd0);
    reset_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc = acc | {52'd0, bus.dispense_sig, bus.busy, bus.done_pulse};
    end
    chk("start_through_reset", 0, acc, 64'd0);
    $display("[TB] reset release with start held: activity=%h", acc);
    bus.start = '0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) run_group(v, 1, 1'b0);

    // on_time == 0: done next cycle, valve never opens.
    set_ch(1, 31'd0, 31'd4, 8'd3);
    bus.start[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("zero_on_done", 1, {61'd0, bus.done_pulse[1], bus.dispense_sig[1], bus.busy[1]}, 64'b100);
    @(negedge clk);
    chk("zero_on_after", 1, {61'd0, bus.done_pulse[1], bus.dispense_sig[1], bus.busy[1]}, 64'b000);
    $display("[TB] on_time=0 trigger on ch1");
    bus.start = '0;
    repeat (2) @(negedge clk);

    // Second start edge inside an off=0 train is ignored.
    set_ch(2, 31'd4, 31'd0, 8'd2);
    bus.start[2] = 1'b1;
    @(posedge clk);
    acc = '0; dacc = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) bus.start[2] = 1'b0;
      if (i == 2) bus.start[2] = 1'b1;
      acc[i]  = bus.dispense_sig[2];
      dacc[i] = bus.done_pulse[2];
    end
    chk("retrigger_pattern", 2, acc, 64'hFF);
    chk("retrigger_done", 2, dacc, 64'd1 << 8);
    $display("[TB] ch2 retrigger during train: pattern=%h", acc);
    bus.start = '0;
    repeat (2) @(negedge clk);

    // Abort on the 3rd ON cycle, abort blocking a start, then a full run.
    set_ch(0, 31'd10, 31'd0, 8'd1);
    bus.start[0] = 1'b1;
    @(posedge clk);
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hi += int'(bus.dispense_sig[0]);
    end
    chk("abort_pre_high", 0, 64'(hi), 64'd3);
    bus.abort[0] = 1'b1;
    @(negedge clk);
    chk("abort_drop", 0, {62'd0, bus.dispense_sig[0], bus.busy[0]}, 64'd0);
    bus.start[0] = 1'b0;
    @(negedge clk);
    bus.start[0] = 1'b1;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acc = acc | {61'd0, bus.dispense_sig[0], bus.busy[0], bus.done_pulse[0]};
    end
    bus.abort[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acc = acc | {61'd0, bus.dispense_sig[0], bus.busy[0], bus.done_pulse[0]};
    end
    chk("abort_quiet", 0, acc, 64'd0);
    bus.start[0] = 1'b0;
    @(negedge clk);
    bus.start[0] = 1'b1;
    @(posedge clk);
    acc = '0; dacc = '0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      acc[i]  = bus.dispense_sig[0];
      dacc[i] = bus.done_pulse[0];
    end
    chk("post_abort_run", 0, acc, 64'h3FF);
    chk("post_abort_done", 0, dacc, 64'd1 << 10);
    $display("[TB] ch0 abort then rerun: pattern=%h", acc);
    bus.start = '0;
    repeat (2) @(negedge clk);

    // All four channels together; inputs rewritten mid-run must not matter.
    run_group(0, 4, 1'b1);

    // Reset mid-train: valve drops without waiting for a clock edge.
    set_ch(3, 31'd10, 31'd0, 8'd1);
    bus.start[3] = 1'b1;
    @(posedge clk);
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_drop", 3, {62'd0, bus.dispense_sig[3], bus.busy[3]}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acc = acc | {52'd0, bus.dispense_sig, bus.busy, bus.done_pulse};
    end
    chk("after_mid_reset", 3, acc, 64'd0);
    $display("[TB] ch3 reset mid-train: activity=%h", acc);
    bus.start = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
